// File: rtl/fetch_stage.sv
`default_nettype none
// =============================================================================
// fetch_stage : in-order instruction fetch with a DEPTH-entry buffer, credit-
//               limited outstanding requests and redirect/flush handling.
// Revision    : 1.0
// =============================================================================
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2,
  parameter logic [31:0] NOP      = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        EN,
  input  logic        Redirect,
  input  logic [31:0] RedirectPC,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic [31:0] Instr,
  output logic [31:0] PC,
  output logic [31:0] PC_plus_4,
  output logic        InstrValid
);

  localparam int             CW      = 3;
  localparam int             PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int             SLOTS   = 1 << PW;
  localparam logic [CW-1:0]  DEPTH_C = CW'(DEPTH);
  localparam logic [PW-1:0]  LAST_C  = PW'(DEPTH - 1);

  logic [31:0]   fpc;
  logic [CW-1:0] count;
  logic [CW-1:0] inflight;
  logic [CW-1:0] drop;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [31:0]   buf_instr [SLOTS];
  logic [31:0]   buf_pc    [SLOTS];

  logic [CW-1:0] live;
  logic [CW:0]   credit_use;
  logic [CW-1:0] inflight_after_resp;
  logic [31:0]   live_pc;
  logic          handshake;
  logic          resp_any;
  logic          resp_drop;
  logic          push;
  logic          pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == LAST_C) ? '0 : p + PW'(1);
  endfunction

  assign live                = inflight - drop;
  assign credit_use          = {1'b0, live} + {1'b0, count};
  assign imem_req_valid      = !Redirect && (inflight < DEPTH_C) && (credit_use < {1'b0, DEPTH_C});
  assign imem_addr           = fpc;
  assign handshake           = imem_req_valid && imem_req_ready;
  assign resp_any            = imem_resp_valid && (inflight != '0);
  assign resp_drop           = resp_any && (drop != '0);
  assign push                = resp_any && (drop == '0) && !Redirect;
  assign pop                 = EN && InstrValid && !Redirect;
  assign inflight_after_resp = inflight - {{(CW-1){1'b0}}, resp_any};

  // Live requests since the last redirect are consecutive words ending just below fpc.
  assign live_pc = fpc - {27'b0, live, 2'b00};

  assign InstrValid = (count != '0);
  assign Instr      = InstrValid ? buf_instr[rd_ptr] : NOP;
  assign PC         = InstrValid ? buf_pc[rd_ptr] : 32'h0;
  assign PC_plus_4  = InstrValid ? buf_pc[rd_ptr] + 32'd4 : 32'h0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fpc      <= RESET_PC & 32'hFFFF_FFFC;
      count    <= '0;
      inflight <= '0;
      drop     <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else if (Redirect) begin
      fpc      <= RedirectPC & 32'hFFFF_FFFC;
      count    <= '0;
      rd_ptr   <= wr_ptr;
      inflight <= inflight_after_resp;
      drop     <= inflight_after_resp;
    end else begin
      if (handshake) fpc <= fpc + 32'd4;
      inflight <= inflight_after_resp + {{(CW-1){1'b0}}, handshake};
      if (resp_drop) drop <= drop - CW'(1);
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop) rd_ptr <= next_ptr(rd_ptr);
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !push) begin
        count <= count - CW'(1);
      end
    end
  end

  // Buffer storage carries no reset; count gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_instr[wr_ptr] <= imem_resp_data;
      buf_pc[wr_ptr]    <= live_pc;
    end
  end

endmodule
`default_nettype wire
